uart_tx_unit: RTL and testbench

//   Serial transmitter for the debug link: the outbound half of the UART pair. The debug unit's
//   tx_start/data_out handshake feeds it, and it returns tx_done_tick.
//   - Serialises one byte per request, LSB first: start bit, DBIT data bits, optional parity bit,

---
 rtl/uart_tx_unit.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// ---------------------------------------------------------------------------
// uart_tx_unit
//   Outbound half of the debug-link UART. It serialises one byte per accepted
//   request, LSB first: start bit, DBIT data bits, an optional even-parity
//   bit, and then the stop period. Bit timing is taken from an external 16x
//   oversampling tick (s_tick). The receiver uses the same tick.
//
//   Build option:
//     UART_TX_PARITY_EN - when this macro is defined, a PARITY state sends an
//                         even-parity bit after the data bits. When it is
//                         undefined, DATA goes straight to STOP. The setting
//                         must match the receiver.
//
//   Parameters:
//     DBIT     data bits per frame (5..8). Only din[DBIT-1:0] is sent.
//     SB_TICK  s_ticks spent in stop (16 = 1, 24 = 1.5, 32 = 2 stop bits).
//
//   Ports:
//     clk           in   system clock, rising edge
//     reset         in   asynchronous, active-high reset
//     tx_start      in   send request; sampled only while idle
//     s_tick        in   1-cycle baud tick, 16 per bit period
//     din[7:0]      in   byte to send; captured when tx_start is accepted
//     tx            out  serial line, idle high, registered
//     tx_done_tick  out  1-cycle pulse on the final stop tick
//     tx_busy       out  high while a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx_unit #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_done_tick,
  output logic       tx_busy
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DBIT);

  function automatic logic even_parity(input logic [7:0] d);
    return ^(d & DATA_MASK);
  endfunction
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state_p0, state_nxt;
  logic [4:0]  s_p0, s_nxt;
  logic [2:0]  n_p0, n_nxt;
  logic [7:0]  shift_p0, shift_nxt;
  logic        tx_nxt;
  logic        tx_p1;
`ifdef UART_TX_PARITY_EN
  logic        par_p0, par_nxt;
`endif

  // ---- stage p0: frame sequencer state -----------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= IDLE;
      s_p0     <= '0;
      n_p0     <= '0;
      shift_p0 <= '0;
`ifdef UART_TX_PARITY_EN
      par_p0   <= 1'b0;
`endif
    end else begin
      state_p0 <= state_nxt;
      s_p0     <= s_nxt;
      n_p0     <= n_nxt;
      shift_p0 <= shift_nxt;
`ifdef UART_TX_PARITY_EN
      par_p0   <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state_p0;
    s_nxt        = s_p0;
    n_nxt        = n_p0;
    shift_nxt    = shift_p0;
    tx_nxt       = 1'b1;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt      = par_p0;
`endif
    case (state_p0)
      IDLE: begin
        // s_tick is deliberately ignored here, so a frame always starts
        // with a full 16-tick start bit.
        tx_nxt = 1'b1;
        if (tx_start) begin
          shift_nxt = din;
          s_nxt     = '0;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          par_nxt   = even_parity(din);
`endif
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (s_tick) begin
          if (s_p0 == 5'd15) begin
            s_nxt     = '0;
            n_nxt     = '0;
            state_nxt = DATA;
          end else begin
            s_nxt = s_p0 + 5'd1;
          end
        end
      end
      DATA: begin
        tx_nxt = shift_p0[0];
        if (s_tick) begin
          if (s_p0 == 5'd15) begin
            s_nxt     = '0;
            shift_nxt = shift_p0 >> 1;
            if (n_p0 == 3'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              n_nxt = n_p0 + 3'd1;
            end
          end else begin
            s_nxt = s_p0 + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_nxt = par_p0;
        if (s_tick) begin
          if (s_p0 == 5'd15) begin
            s_nxt     = '0;
            state_nxt = STOP;
          end else begin
            s_nxt = s_p0 + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        tx_nxt = 1'b1;
        if (s_tick) begin
          if (s_p0 == 5'(SB_TICK - 1)) begin
            // The FSM is still in STOP during this cycle, so a tx_start
            // that coincides with the done pulse waits one more cycle.
            tx_done_tick = 1'b1;
            state_nxt    = IDLE;
          end else begin
            s_nxt = s_p0 + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: registered line driver, one clk behind the sequencer ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_p1 <= 1'b1;
    else       tx_p1 <= tx_nxt;
  end

  assign tx      = tx_p1;
  assign tx_busy = (state_p0 != IDLE);

endmodule

// File: tb/tb_uart_tx_unit.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_unit
//   Scoreboard bench for uart_tx_unit (DBIT=8, SB_TICK=16). Each request
//   pushes its expected frame and expected frame length into queues. Two
//   monitors pop those entries when the DUT starts a frame or pulses
//   tx_done_tick. Inputs change 1 time unit after the rising edge, and
//   the bench samples signals on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_unit;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS       = 11;
  localparam int FRAME_TICKS = 176;
`else
  localparam int NBITS       = 10;
  localparam int FRAME_TICKS = 160;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
  logic       tx;
  logic       tx_done_tick;
  logic       tx_busy;

  uart_tx_unit #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .din          (din),
    .tx           (tx),
    .tx_done_tick (tx_done_tick),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       par;
    bit         abort;
  } exp_t;

  exp_t bit_q[$];
  int   done_q[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  int   tp        = 4;
  int   done_seen = 0;
  bit   mon_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input exp_t e, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return e.d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return e.par;
`endif
    return 1'b1;
  endfunction

  // Baud tick generator: one tick every tp clocks.
  initial begin
    int tcnt = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      s_tick = ((tcnt % tp) == 0);
    end
  end

  // Line monitor: when a frame starts, it samples the middle of every bit.
  initial begin
    wait (mon_en);
    forever begin
      exp_t e;
      bit   ab;
      int   bp;
      @(negedge clk);
      if (tx === 1'b0 && !reset) begin
        if (bit_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: start bit seen, expected line idle");
          for (int c = 0; c < 5000 && tx_busy !== 1'b0; c++) @(negedge clk);
        end else begin
          e  = bit_q.pop_front();
          ab = 1'b0;
          bp = 16 * tp;
          for (int b = 0; b < NBITS && !ab; b++) begin
            for (int c = 0; c < ((b == 0) ? bp / 2 : bp) && !ab; c++) begin
              @(negedge clk);
              if (reset) ab = 1'b1;
            end
            if (!ab)
              check($sformatf("frame_%02h_bit%0d", e.d, b), tx, exp_bit(e, b));
          end
          check($sformatf("frame_%02h_aborted", e.d), ab, e.abort);
        end
      end
    end
  end

  // Done monitor: counts the s_ticks of each frame up to its done pulse.
  initial begin
    int ticks = 0;
    int exp_ticks;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (reset) begin
        ticks = 0;
      end else begin
        if (s_tick && tx_busy) ticks++;
        if (tx_done_tick) begin
          done_seen++;
          if (done_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: tx_done_tick=1, expected 0 (no frame outstanding)");
          end else begin
            exp_ticks = done_q.pop_front();
            check("frame_ticks", ticks, exp_ticks);
          end
          ticks = 0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [7:0] d, input logic p, input bit ab);
    @(posedge clk);
    #1;
    din      = d;
    tx_start = 1'b1;
    bit_q.push_back('{d: d, par: p, abort: ab});
    if (!ab) done_q.push_back(FRAME_TICKS);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    @(negedge clk);
    check("lat_busy", tx_busy, 1'b1);
    check("lat_tx_hold", tx, 1'b1);
    @(negedge clk);
    check("lat_tx_fall", tx, 1'b0);
  endtask

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while ((tx_busy !== 1'b0 || bit_q.size() != 0 || done_q.size() != 0) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy=%b after %0d clks, expected idle", tx_busy, c);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int c;
    reset    = 1'b1;
    tx_start = 1'b0;
    din      = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done_tick, 1'b0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle with no request.
    repeat (40) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", tx_busy, 1'b0);
      check("idle_done", tx_done_tick, 1'b0);
    end

    // Basic frames. Parity is computed by hand: A5 -> 0, 07 -> 1, 03 -> 0.
    send(8'hA5, 1'b0, 1'b0);
    wait_idle();
    send(8'h07, 1'b1, 1'b0);
    wait_idle();
    send(8'h03, 1'b0, 1'b0);
    wait_idle();

    // A request and a din change mid-frame are both ignored (96 -> parity 0).
    send(8'h96, 1'b0, 1'b0);
    repeat (3 * 64) @(posedge clk);
    #1;
    din      = 8'hFF;
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_idle();
    repeat (200) @(negedge clk);

    // tx_start held across two frames (55 -> parity 0).
    base = done_seen;
    @(posedge clk);
    #1;
    din      = 8'h55;
    tx_start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bit_q.push_back('{d: 8'h55, par: 1'b0, abort: 1'b0});
      done_q.push_back(FRAME_TICKS);
    end
    c = 0;
    @(negedge clk);
    while (tx_done_tick !== 1'b1 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL b2b_first_done: no tx_done_tick within %0d clks, expected one", c);
    end
    @(negedge clk);
    check("b2b_gap_busy", tx_busy, 1'b0);
    check("b2b_gap_tx", tx, 1'b1);
    @(negedge clk);
    check("b2b_restart_busy", tx_busy, 1'b1);
    check("b2b_idle_clk_tx", tx, 1'b1);
    @(negedge clk);
    check("b2b_start_bit", tx, 1'b0);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    wait_idle();
    check("b2b_done_count", done_seen - base, 2);

    // s_tick held high continuously (80 -> parity 1).
    tp = 1;
    send(8'h80, 1'b1, 1'b0);
    wait_idle();
    tp = 4;
    repeat (8) @(negedge clk);

    // Reset asserted in the middle of the third data bit.
    send(8'hC3, 1'b0, 1'b1);
    repeat (3 * 64 + 32) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", tx_busy, 1'b0);
    check("rst_mid_done", tx_done_tick, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_done", tx_done_tick, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h81, 1'b0, 1'b0);
    wait_idle();

    repeat (50) @(negedge clk);
    check("bit_q_empty", bit_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
